// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types and defaults for the I/D memory port arbiter.
//   CPU_WIDTH / DEF_AW / DEF_DW : default address and data widths of the core
//   STREAK_W                    : width of the D-over-I streak counter
//   resp_tag_e                  : which port owns the read response in flight
package mem_port_arbiter_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int DEF_AW    = CPU_WIDTH;
  localparam int DEF_DW    = CPU_WIDTH;
  localparam int STREAK_W  = 4;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_I    = 2'd1,
    TAG_D    = 2'd2
  } resp_tag_e;

endpackage

// File: rtl/mem_port_starve_cnt.sv
// mem_port_starve_cnt
// Counts consecutive D grants taken while I was waiting and raises force_i
// once MAX_D_STREAK is reached, so the fetch port cannot be starved.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_req      : fetch port is requesting
//   i_gnt      : fetch port granted this cycle
//   d_gnt      : load/store port granted this cycle
//   mem_ready  : memory accepting commands; streak frozen while low
//   force_i    : streak saturated, I must win the next contention
module mem_port_starve_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_gnt,
  input  logic d_gnt,
  input  logic mem_ready,
  output logic force_i
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_reg <= '0;
    end else if (mem_ready) begin
      // A stalled memory freezes the streak so fairness survives the stall.
      if (i_gnt || !i_req) begin
        streak_reg <= '0;
      end else if (d_gnt && (streak_reg != MAX_STREAK)) begin
        streak_reg <= streak_reg + 1'b1;
      end
    end
  end

  assign force_i = (streak_reg >= MAX_STREAK);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port, synchronous-read memory between the instruction
// fetch port (I) and the load/store port (D). At most one command is issued
// per cycle; each read response is steered back to its requester one cycle
// after the grant.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   i_req/i_addr                   : fetch request (read only)
//   i_gnt/i_rvalid/i_rdata/i_stall : fetch grant, response, stall
//   d_req/d_we/d_be/d_addr/d_wdata : load/store request
//   d_gnt/d_rvalid/d_rdata/d_stall : load/store grant, response, stall
//   mem_ready                      : memory can take a command
//   mem_en/we/be/addr/wdata        : memory command
//   mem_rdata                      : read data, one cycle after a read
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          mem_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          i_stall,
  output logic          d_stall
);

  logic      force_i;
  logic      d_pick;
  logic      i_pick;
  logic      can_issue;
  resp_tag_e tag_reg;

  mem_port_starve_cnt #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_starve_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_gnt    (i_gnt),
    .d_gnt    (d_gnt),
    .mem_ready(mem_ready),
    .force_i  (force_i)
  );

  // D has priority unless I is waiting and the D streak is exhausted.
  assign d_pick    = d_req && (!i_req || !force_i);
  assign i_pick    = i_req && !d_pick;
  // Outputs are held at zero while reset is asserted.
  assign can_issue = !rst && mem_ready;
  assign d_gnt     = can_issue && d_pick;
  assign i_gnt     = can_issue && i_pick;
  assign mem_en    = i_gnt || d_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (i_gnt) begin
      mem_be   = '1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // Response owner for the data arriving next cycle; stores return nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_reg <= TAG_NONE;
    end else if (i_gnt) begin
      tag_reg <= TAG_I;
    end else if (d_gnt && !d_we) begin
      tag_reg <= TAG_D;
    end else begin
      tag_reg <= TAG_NONE;
    end
  end

  // Gating by rst drops a response that was in flight when reset hit.
  assign i_rvalid = !rst && (tag_reg == TAG_I);
  assign d_rvalid = !rst && (tag_reg == TAG_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  assign i_stall = !rst && i_req && !i_gnt;
  assign d_stall = !rst && d_req && !d_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_ready = 1'b0;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        i_stall, d_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ready(mem_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .i_stall(i_stall), .d_stall(d_stall)
  );

  // Scoreboard entry: owner of the response due next cycle (0 none, 1 I, 2 D).
  typedef struct {
    int          who;
    logic [31:0] data;
  } resp_t;
  resp_t sb[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // Reference model state
  int   m_streak = 0;
  logic p_rst = 1'b1, p_rdy = 1'b0, p_ig = 1'b0, p_dg = 1'b0, p_ireq = 1'b0;
  logic [73:0] exp_cmd;
  logic [65:0] exp_rsp;
  logic        exp_ig, exp_dg;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return 32'h1000_0000 + a * 3;
  endfunction

  // Drive one cycle of inputs after the active edge, model the expected
  // grant/command and the response due this cycle.
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [3:0] db,
                       input logic [31:0] da, input logic [31:0] dwd, input logic rdy);
    resp_t cur;
    resp_t nxt;
    logic  irv, drv;
    @(posedge clk);
    #1;
    cyc++;
    if (p_rst) m_streak = 0;
    else if (p_rdy) begin
      if (p_ig || !p_ireq) m_streak = 0;
      else if (p_dg && m_streak < MAX) m_streak = m_streak + 1;
    end
    if (sb.size() > 0) cur = sb.pop_front();
    else begin cur.who = 0; cur.data = '0; end
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_be = db;
    d_addr = da; d_wdata = dwd; mem_ready = rdy;
    mem_rdata = (cur.who != 0) ? cur.data : (32'hCAFE_0000 ^ 32'(cyc));
    irv = !r && cur.who == 1;
    drv = !r && cur.who == 2;
    exp_rsp = {irv, irv ? cur.data : 32'h0, drv, drv ? cur.data : 32'h0};
    exp_dg = !r && rdy && dr && (!ir || m_streak < MAX);
    exp_ig = !r && rdy && ir && !exp_dg;
    exp_cmd = {exp_ig, exp_dg, exp_ig | exp_dg, exp_dg & dw,
               exp_ig ? 4'hF : (exp_dg ? db : 4'h0),
               exp_ig ? ia : (exp_dg ? da : 32'h0),
               exp_dg ? dwd : 32'h0,
               !r && ir && !exp_ig, !r && dr && !exp_dg};
    nxt.who  = exp_ig ? 1 : ((exp_dg && !dw) ? 2 : 0);
    nxt.data = mem_val(exp_ig ? ia : da);
    sb.push_back(nxt);
    p_rst = r; p_rdy = rdy; p_ig = exp_ig; p_dg = exp_dg; p_ireq = ir;
    #2;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 4'h0, 0, 0, 1);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      drive(1, 1, 32'h20, 1, 0, 4'hF, 32'h24, 0, 1);
      total_cnt++;
      if ({i_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata, i_stall, d_stall} !== 74'h0)
        $display("FAIL reset_cmd: got %0h expected 0",
                 {i_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata, i_stall, d_stall});
      else pass_cnt++;
      total_cnt++;
      if ({i_rvalid, i_rdata, d_rvalid, d_rdata} !== 66'h0)
        $display("FAIL reset_rsp: got %0h expected 0", {i_rvalid, i_rdata, d_rvalid, d_rdata});
      else pass_cnt++;
    end
    $display("reset: outputs checked during reset");
  endtask

  task automatic test_fetch();
    drive(0, 1, 32'h10, 0, 0, 4'h0, 0, 0, 1);
    total_cnt++;
    if ({i_gnt, mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b1, 1'b0, 4'hF, 32'h10})
      $display("FAIL fetch_cmd: got gnt=%b en=%b we=%b be=%h addr=%h expected 1 1 0 f 10",
               i_gnt, mem_en, mem_we, mem_be, mem_addr);
    else pass_cnt++;
    idle();
    total_cnt++;
    if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0})
      $display("FAIL fetch_rsp: got i_rvalid=%b i_rdata=%h d_rvalid=%b expected 1 deadbeef 0",
               i_rvalid, i_rdata, d_rvalid);
    else pass_cnt++;
    $display("fetch: addr=0x10 rdata=%h", i_rdata);
  endtask

  task automatic test_streak();
    string pat;
    string got;
    pat = "DDDDIDDDDI";
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'h80, 1, 0, 4'hF, 32'h200, 0, 1);
      got = d_gnt ? "D" : (i_gnt ? "I" : "-");
      total_cnt++;
      if ({d_gnt, i_gnt} !== {pat[k] == "D", pat[k] == "I"})
        $display("FAIL streak_order[%0d]: got %s expected %s", k, got, pat.substr(k, k));
      else pass_cnt++;
      total_cnt++;
      if ({i_rvalid, i_rdata, d_rvalid, d_rdata} !== exp_rsp)
        $display("FAIL streak_rsp[%0d]: got %0h expected %0h", k,
                 {i_rvalid, i_rdata, d_rvalid, d_rdata}, exp_rsp);
      else pass_cnt++;
      $display("streak: cycle %0d grant %s", k, got);
    end
    idle();
  endtask

  task automatic test_store();
    drive(0, 0, 0, 1, 1, 4'b0011, 32'h43, 32'h1234, 1);
    total_cnt++;
    if ({d_gnt, mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 1'b1, 4'b0011, 32'h43, 32'h1234})
      $display("FAIL store_cmd: got gnt=%b we=%b be=%b addr=%h wdata=%h expected 1 1 0011 43 1234",
               d_gnt, mem_we, mem_be, mem_addr, mem_wdata);
    else pass_cnt++;
    idle();
    total_cnt++;
    if ({d_rvalid, d_rdata, i_rvalid} !== {1'b0, 32'h0, 1'b0})
      $display("FAIL store_no_rsp: got d_rvalid=%b d_rdata=%h i_rvalid=%b expected 0 0 0",
               d_rvalid, d_rdata, i_rvalid);
    else pass_cnt++;
    $display("store: addr=0x43 be=0011 wdata=0x1234");
  endtask

  task automatic test_not_ready();
    logic [7:0] rdy_pat;
    string      pat;
    // Simple stall on I alone, then release.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h30, 0, 0, 4'h0, 0, 0, k == 3);
      total_cnt++;
      if ({i_gnt, i_stall, mem_en} !== ((k == 3) ? 3'b101 : 3'b010))
        $display("FAIL not_ready_i[%0d]: got gnt=%b stall=%b en=%b", k, i_gnt, i_stall, mem_en);
      else pass_cnt++;
    end
    idle();
    // Contention across a stall: streak held, in-flight D response returns.
    rdy_pat = 8'b1110_0011;  // bit k = mem_ready in cycle k
    pat = "DD---DDI";
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, 32'h34, 1, 0, 4'hF, 32'h300, 0, rdy_pat[k]);
      total_cnt++;
      if ({d_gnt, i_gnt} !== {pat[k] == "D", pat[k] == "I"})
        $display("FAIL stall_order[%0d]: got d=%b i=%b expected %s", k, d_gnt, i_gnt, pat.substr(k, k));
      else pass_cnt++;
      total_cnt++;
      if ({i_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata, i_stall, d_stall} !== exp_cmd)
        $display("FAIL stall_cmd[%0d]: got %0h expected %0h", k,
                 {i_gnt, d_gnt, mem_en, mem_we, mem_be, mem_addr, mem_wdata, i_stall, d_stall}, exp_cmd);
      else pass_cnt++;
      if (k == 2) begin
        total_cnt++;
        if ({d_rvalid, d_rdata} !== {1'b1, mem_val(32'h300)})
          $display("FAIL stall_inflight_rsp: got %b %h expected 1 %h", d_rvalid, d_rdata, mem_val(32'h300));
        else pass_cnt++;
      end
      $display("not_ready: cycle %0d ready=%b d_gnt=%b i_gnt=%b", k, rdy_pat[k], d_gnt, i_gnt);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    addrs[0] = 32'h0; addrs[1] = 32'h100; addrs[2] = 32'h4;
    drive(0, 1, addrs[0], 0, 0, 4'h0, 0, 0, 1);
    drive(0, 0, 0, 1, 0, 4'hF, addrs[1], 0, 1);
    total_cnt++;
    if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, mem_val(addrs[0]), 1'b0})
      $display("FAIL b2b_rsp0: got i=%b %h d=%b", i_rvalid, i_rdata, d_rvalid);
    else pass_cnt++;
    drive(0, 1, addrs[2], 0, 0, 4'h0, 0, 0, 1);
    total_cnt++;
    if ({d_rvalid, d_rdata, i_rvalid, i_gnt} !== {1'b1, mem_val(addrs[1]), 1'b0, 1'b1})
      $display("FAIL b2b_rsp1: got d=%b %h i=%b gnt=%b", d_rvalid, d_rdata, i_rvalid, i_gnt);
    else pass_cnt++;
    idle();
    total_cnt++;
    if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, mem_val(addrs[2]), 1'b0})
      $display("FAIL b2b_rsp2: got i=%b %h d=%b", i_rvalid, i_rdata, d_rvalid);
    else pass_cnt++;
    $display("back_to_back: I,D,I responses checked");
  endtask

  task automatic test_reset_mid();
    drive(0, 1, 32'h10, 0, 0, 4'h0, 0, 0, 1);
    drive(1, 1, 32'h14, 1, 0, 4'hF, 32'h50, 0, 1);
    total_cnt++;
    if ({i_rvalid, i_rdata, d_rvalid, d_rdata, i_gnt, d_gnt, mem_en, i_stall, d_stall} !== 71'h0)
      $display("FAIL rst_mid_outputs: got i_rvalid=%b i_gnt=%b d_gnt=%b mem_en=%b stall=%b%b",
               i_rvalid, i_gnt, d_gnt, mem_en, i_stall, d_stall);
    else pass_cnt++;
    idle();
    total_cnt++;
    if ({i_rvalid, d_rvalid} !== 2'b00)
      $display("FAIL rst_mid_no_rsp: got i_rvalid=%b d_rvalid=%b expected 0 0", i_rvalid, d_rvalid);
    else pass_cnt++;
    // Build a streak, reset, then confirm the full D allowance is available again.
    drive(0, 1, 32'h60, 1, 0, 4'hF, 32'h64, 0, 1);
    drive(0, 1, 32'h60, 1, 0, 4'hF, 32'h64, 0, 1);
    drive(1, 1, 32'h60, 1, 0, 4'hF, 32'h64, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 1, 32'h60, 1, 0, 4'hF, 32'h64, 0, 1);
      total_cnt++;
      if ({d_gnt, i_gnt} !== ((k == 4) ? 2'b01 : 2'b10))
        $display("FAIL rst_streak[%0d]: got d=%b i=%b", k, d_gnt, i_gnt);
      else pass_cnt++;
    end
    idle();
    $display("reset_mid: response dropped, streak cleared");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_streak();
    test_store();
    test_not_ready();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
